regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, meaning depth of the mult/div result queue.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port wbValid  in  1  memory/writeback-stage instruction writes a register this cycle.
REQ-005 SHALL have port wbReg  in  5  writeback destination register.
REQ-006 SHALL have port wbData  in  32  writeback data.
REQ-007 SHALL have port mdReady  in  1  one-cycle pulse: mult/div result available.
REQ-008 SHALL have port mdReg  in  5  mult/div destination register.
REQ-009 SHALL have port mdData  in  32  mult/div result.
REQ-010 SHALL have ports readA and readB  in  5  each  decode-stage source registers.
REQ-011 SHALL have port wE  out  1  register-file write enable.
REQ-012 SHALL have port writeD  out  5  register-file write address.
REQ-013 SHALL have port writeData  out  32  register-file write data.
REQ-014 SHALL have port mdBusy  out  1  queue full; mult/div unit must not pulse mdReady.
REQ-015 SHALL have ports pendA and pendB  out  1  each  readA/readB matches a queued result; decode must stall.
REQ-016 SHALL have port overflow  out  1  sticky: a result arrived while the queue was full.

Function
REQ-017 SHALL give the writeback stage absolute priority: wbValid=1 drives the port with wbReg/wbData in the same cycle (0-cycle latency).
REQ-018 SHALL, with wbValid=0 and a non-empty queue, write the queue head and pop it at the clock edge.
REQ-019 SHALL, with wbValid=0, an empty queue and mdReady=1, write mdReg/mdData in the same cycle (bypass, no enqueue).
REQ-020 SHALL otherwise enqueue an arriving mdReady result at the tail; write order SHALL be arrival order.
REQ-021 SHALL allow pop and push in the same cycle; count is unchanged and the new entry goes behind the remaining entries.
REQ-022 SHALL never assert wE for register 0; results for r0 are never enqueued and never raise pendA/pendB.
REQ-023 SHALL, when wbValid=1 and wbReg matches a valid queued entry, invalidate that entry (WAW: the pipeline write is younger); invalidated entries are dropped at the head without a write and without a stall cycle.
REQ-024 SHALL, when wbValid=1, mdReady=1 and wbReg==mdReg, discard the mult/div result.
REQ-025 SHALL drive wE=0, writeD=0, writeData=0 when nothing is written.
REQ-026 SHALL assert mdBusy combinationally when the valid-or-invalidated entry count equals QDEPTH.
REQ-027 SHALL, on mdReady=1 with the queue full and no pop that cycle, drop the result and set overflow until reset.
REQ-028 SHALL assert pendA (pendB) combinationally when readA (readB) is nonzero and equals the register of any valid queued entry.
REQ-029 SHALL not consider the bypassed (REQ-019) result pending.

Reset
REQ-030 SHALL, on reset, clear the queue (count 0, all entries invalid) immediately and asynchronously, including any entries mid-drain.
REQ-031 SHALL, during and after reset, drive wE=0, writeD=0, writeData=0, mdBusy=0, pendA=pendB=0, overflow=0.
REQ-032 SHALL discard any mdReady pulse coincident with reset.

Structure
REQ-033 SHALL place REG_W=32, ADDR_W=5, QDEPTH default and the queue-entry record (valid, reg, data) in the processor's shared package.
REQ-034 SHALL implement the queue as one sub-module md_result_queue (push, pop, head, per-entry valid/reg for match, invalidate-by-reg); arbitration stays in the top.

Verification
REQ-035 SHALL cover: wbValid=1 wbReg=3 wbData=0xA, mdReady=1 mdReg=7 mdData=0xB -> cycle 0 writes r3=0xA, cycle 1 writes r7=0xB; pendA=1 in cycle 0 when readA=7.
REQ-036 SHALL cover: idle, mdReady=1 mdReg=9 mdData=0x55 -> same-cycle wE=1 writeD=9 writeData=0x55, queue stays empty, pendA=0 with readA=9.
REQ-037 SHALL cover: wbValid held high 3 cycles, mdReady at cycles 0 and 1 (r4, r5) -> mdBusy=1 from cycle 2; third mdReady at cycle 2 -> overflow=1; after wbValid drops, r4 then r5 written.
REQ-038 SHALL cover: r6 queued, then wbValid=1 wbReg=6 wbData=0x1 -> r6=0x1 written, queued r6 never written, pend on r6 clears the next cycle.
REQ-039 SHALL cover: mdReady mdReg=0 while idle -> wE=0; wbValid=1 wbReg=0 -> wE=0.
REQ-040 SHALL cover: two entries queued, reset asserted mid-cycle -> wE, mdBusy, pendA/pendB drop immediately; no queued write after reset release.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared processor definitions: datapath widths, result-queue depth and the queue-entry record.
package regfile_write_arbiter_pkg;

    localparam int unsigned REG_W          = 32;
    localparam int unsigned ADDR_W         = 5;
    localparam int unsigned QDEPTH_DEFAULT = 2;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [REG_W-1:0]  data;
    } md_entry_t;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/md_result_queue.sv
// In-order mult/div result queue: tail push, multi-entry head pop, invalidate-by-register.
module md_result_queue
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned QDEPTH = QDEPTH_DEFAULT,
    localparam int unsigned CNT_W = cnt_width(QDEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [ADDR_W-1:0]       push_reg_i,
    input  logic [REG_W-1:0]        push_data_i,
    input  logic [CNT_W-1:0]        pop_n_i,
    input  logic                    inv_i,
    input  logic [ADDR_W-1:0]       inv_reg_i,
    output md_entry_t [QDEPTH-1:0]  entries_o,
    output logic [CNT_W-1:0]        count_o
);

    md_entry_t [QDEPTH-1:0] ent_q, ent_d, ent_inv;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_pop;

    // Invalidate first, then shift out popped slots, then append behind the survivors.
    always_comb begin
        ent_inv = ent_q;
        ent_d   = '0;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            if (inv_i && ent_q[i].valid && (ent_q[i].rd == inv_reg_i)) begin
                ent_inv[i].valid = 1'b0;
            end
        end
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            for (int unsigned j = 0; j < QDEPTH; j++) begin
                if (j == i + 32'(pop_n_i)) begin
                    ent_d[i] = ent_inv[j];
                end
            end
        end
        cnt_pop = cnt_q - pop_n_i;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            if (push_i && (i == 32'(cnt_pop))) begin
                ent_d[i].valid = 1'b1;
                ent_d[i].rd    = push_reg_i;
                ent_d[i].data  = push_data_i;
            end
        end
        cnt_d = cnt_pop + CNT_W'(push_i);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent_q <= '0;
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign entries_o = ent_q;
    assign count_o   = cnt_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: writeback has priority, mult/div results are
// bypassed when possible and otherwise queued in arrival order.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned QDEPTH = QDEPTH_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wbValid,
    input  logic [ADDR_W-1:0] wbReg,
    input  logic [REG_W-1:0]  wbData,
    input  logic              mdReady,
    input  logic [ADDR_W-1:0] mdReg,
    input  logic [REG_W-1:0]  mdData,
    input  logic [ADDR_W-1:0] readA,
    input  logic [ADDR_W-1:0] readB,
    output logic              wE,
    output logic [ADDR_W-1:0] writeD,
    output logic [REG_W-1:0]  writeData,
    output logic              mdBusy,
    output logic              pendA,
    output logic              pendB,
    output logic              overflow
);

    localparam int unsigned CNT_W = cnt_width(QDEPTH);

    md_entry_t [QDEPTH-1:0] q_entries;
    logic [CNT_W-1:0]       q_count;
    logic [CNT_W-1:0]       pop_n;
    logic [CNT_W-1:0]       first_valid;
    md_entry_t              head;
    logic                   has_valid;
    logic                   full;
    logic                   bypass;
    logic                   discard;
    logic                   push;
    logic                   inv;
    logic                   overflow_q, overflow_d;

    md_result_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .push_reg_i  (mdReg),
        .push_data_i (mdData),
        .pop_n_i     (pop_n),
        .inv_i       (inv),
        .inv_reg_i   (wbReg),
        .entries_o   (q_entries),
        .count_o     (q_count)
    );

    // Oldest still-valid entry; invalidated entries ahead of it are skipped.
    always_comb begin
        has_valid   = 1'b0;
        first_valid = '0;
        head        = '0;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            if (!has_valid && q_entries[i].valid) begin
                has_valid   = 1'b1;
                first_valid = CNT_W'(i);
                head        = q_entries[i];
            end
        end
    end

    // Dead entries always drain; the first valid one drains only when it gets the port.
    always_comb begin
        full       = (q_count == CNT_W'(QDEPTH));
        pop_n      = (has_valid ? first_valid : q_count) + CNT_W'(!wbValid && has_valid);
        bypass     = !wbValid && !has_valid && mdReady && (mdReg != '0);
        discard    = wbValid && (wbReg == mdReg);
        push       = !reset && mdReady && (mdReg != '0) && !discard && !bypass
                     && (!full || (pop_n != '0));
        inv        = !reset && wbValid && (wbReg != '0);
        overflow_d = overflow_q | (!reset && mdReady && full && (pop_n == '0));
    end

    always_comb begin
        wE        = 1'b0;
        writeD    = '0;
        writeData = '0;
        if (!reset) begin
            if (wbValid) begin
                if (wbReg != '0) begin
                    wE        = 1'b1;
                    writeD    = wbReg;
                    writeData = wbData;
                end
            end else if (has_valid) begin
                wE        = 1'b1;
                writeD    = head.rd;
                writeData = head.data;
            end else if (bypass) begin
                wE        = 1'b1;
                writeD    = mdReg;
                writeData = mdData;
            end
        end
    end

    // A result accepted into the queue this cycle is already a hazard for decode.
    always_comb begin
        pendA = 1'b0;
        pendB = 1'b0;
        if (!reset) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                if (q_entries[i].valid && (readA != '0) && (q_entries[i].rd == readA)) pendA = 1'b1;
                if (q_entries[i].valid && (readB != '0) && (q_entries[i].rd == readB)) pendB = 1'b1;
            end
            if (push && (readA != '0) && (mdReg == readA)) pendA = 1'b1;
            if (push && (readB != '0) && (mdReg == readB)) pendB = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign mdBusy   = !reset && full;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed vector tables plus
// randomized traffic against a queue-based reference model.
module tb_regfile_write_arbiter;

    localparam int QD = 2;

    logic        clock, reset;
    logic        wbValid, mdReady;
    logic [4:0]  wbReg, mdReg, readA, readB;
    logic [31:0] wbData, mdData;
    logic        wE, mdBusy, pendA, pendB, overflow;
    logic [4:0]  writeD;
    logic [31:0] writeData;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.QDEPTH(QD)) dut (
        .clock     (clock),
        .reset     (reset),
        .wbValid   (wbValid),
        .wbReg     (wbReg),
        .wbData    (wbData),
        .mdReady   (mdReady),
        .mdReg     (mdReg),
        .mdData    (mdData),
        .readA     (readA),
        .readB     (readB),
        .wE        (wE),
        .writeD    (writeD),
        .writeData (writeData),
        .mdBusy    (mdBusy),
        .pendA     (pendA),
        .pendB     (pendB),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        wbv;
        logic [4:0]  wbr;
        logic [31:0] wbd;
        logic        mdr;
        logic [4:0]  mdg;
        logic [31:0] mdd;
        logic [4:0]  ra, rb;
        logic        we;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        busy, pa, pb, ovf;
    } vec_t;

    typedef struct {
        bit          valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } ment_t;

    ment_t mq[$];
    bit    m_ovf;

    function automatic vec_t mk(input int wbv, input int wbr, input int wbd,
                                input int mdr, input int mdg, input int mdd,
                                input int ra, input int rb,
                                input int we, input int wd, input int wdata,
                                input int busy, input int pa, input int pb, input int ovf);
        vec_t v;
        v.wbv = 1'(wbv);  v.wbr = 5'(wbr);  v.wbd = 32'(wbd);
        v.mdr = 1'(mdr);  v.mdg = 5'(mdg);  v.mdd = 32'(mdd);
        v.ra  = 5'(ra);   v.rb  = 5'(rb);
        v.we  = 1'(we);   v.wd  = 5'(wd);   v.wdata = 32'(wdata);
        v.busy = 1'(busy); v.pa = 1'(pa);   v.pb = 1'(pb); v.ovf = 1'(ovf);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        wbValid = v.wbv; wbReg = v.wbr; wbData = v.wbd;
        mdReady = v.mdr; mdReg = v.mdg; mdData = v.mdd;
        readA   = v.ra;  readB = v.rb;
    endtask

    task automatic check_outs(input string tag, input logic we, input logic [4:0] wd,
                              input logic [31:0] wdata, input logic busy,
                              input logic pa, input logic pb, input logic ovf);
        chk($sformatf("%s.wE", tag),        32'(wE),        32'(we));
        chk($sformatf("%s.writeD", tag),    32'(writeD),    32'(wd));
        chk($sformatf("%s.writeData", tag), writeData,      wdata);
        chk($sformatf("%s.mdBusy", tag),    32'(mdBusy),    32'(busy));
        chk($sformatf("%s.pendA", tag),     32'(pendA),     32'(pa));
        chk($sformatf("%s.pendB", tag),     32'(pendB),     32'(pb));
        chk($sformatf("%s.overflow", tag),  32'(overflow),  32'(ovf));
    endtask

    // Apply one vector for one cycle, compare mid-cycle, return just after the next edge.
    task automatic run_vec(input string tag, input vec_t v);
        apply(v);
        @(negedge clock);
        check_outs(tag, v.we, v.wd, v.wdata, v.busy, v.pa, v.pb, v.ovf);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        apply(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0));
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
    endtask

    function automatic bit model_pending(input logic [4:0] r, input bit acc);
        if (r == 5'd0) return 1'b0;
        if (acc && mdReg == r) return 1'b1;
        foreach (mq[i]) if (mq[i].valid && mq[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: ordered list of pending results; writeback wins, the oldest live
    // result writes next, dead results vanish for free, fresh results bypass an idle port.
    task automatic model_cycle(output logic we, output logic [4:0] wd, output logic [31:0] wdat,
                               output logic busy, output logic pa, output logic pb, output logic ovf);
        int fv = -1;
        int sz = mq.size();
        int npop;
        bit acc;
        ment_t e;
        for (int i = 0; i < sz; i++) if (fv < 0 && mq[i].valid) fv = i;
        npop = (fv < 0) ? sz : (wbValid ? fv : fv + 1);
        acc  = mdReady && (mdReg != 0) && !(wbValid && wbReg == mdReg)
               && !(!wbValid && fv < 0) && !(sz == QD && npop == 0);
        we = 1'b0; wd = '0; wdat = '0;
        if (wbValid) begin
            if (wbReg != 0) begin we = 1'b1; wd = wbReg; wdat = wbData; end
        end else if (fv >= 0) begin
            we = 1'b1; wd = mq[fv].rd; wdat = mq[fv].data;
        end else if (mdReady && mdReg != 0) begin
            we = 1'b1; wd = mdReg; wdat = mdData;
        end
        busy = (sz == QD);
        pa   = model_pending(readA, acc);
        pb   = model_pending(readB, acc);
        ovf  = m_ovf;
        if (mdReady && sz == QD && npop == 0) m_ovf = 1'b1;
        if (wbValid && wbReg != 0) foreach (mq[i]) if (mq[i].rd == wbReg) mq[i].valid = 1'b0;
        repeat (npop) void'(mq.pop_front());
        if (acc) begin
            e.valid = 1'b1; e.rd = mdReg; e.data = mdData;
            mq.push_back(e);
        end
    endtask

    vec_t tbl[8];
    vec_t ovf_seq[6];

    initial begin
        logic        e_we, e_busy, e_pa, e_pb, e_ovf;
        logic [4:0]  e_wd;
        logic [31:0] e_wdata;

        reset = 1'b1;
        apply(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0));
        #2;
        check_outs("reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Priority, bypass and r0 handling from an empty queue.
        tbl[0] = mk(1,3,'hA, 1,7,'hB,  7,3, 1,3,'hA,  0,1,0,0);
        tbl[1] = mk(0,0,0,   0,0,0,    7,0, 1,7,'hB,  0,1,0,0);
        tbl[2] = mk(0,0,0,   0,0,0,    7,0, 0,0,0,    0,0,0,0);
        tbl[3] = mk(0,0,0,   1,9,'h55, 9,0, 1,9,'h55, 0,0,0,0);
        tbl[4] = mk(0,0,0,   0,0,0,    9,0, 0,0,0,    0,0,0,0);
        tbl[5] = mk(0,0,0,   1,0,'h77, 0,0, 0,0,0,    0,0,0,0);
        tbl[6] = mk(1,0,'h88,0,0,0,    0,0, 0,0,0,    0,0,0,0);
        tbl[7] = mk(0,0,0,   0,0,0,    0,0, 0,0,0,    0,0,0,0);

        // Fill under writeback pressure, overflow on the third result, then drain in order.
        ovf_seq[0] = mk(1,1,'h10, 1,4,'h44, 4,5, 1,1,'h10, 0,1,0,0);
        ovf_seq[1] = mk(1,2,'h20, 1,5,'h45, 4,5, 1,2,'h20, 0,1,1,0);
        ovf_seq[2] = mk(1,3,'h30, 1,6,'h46, 4,5, 1,3,'h30, 1,1,1,0);
        ovf_seq[3] = mk(0,0,0,    0,0,0,    4,5, 1,4,'h44, 1,1,1,1);
        ovf_seq[4] = mk(0,0,0,    0,0,0,    4,5, 1,5,'h45, 0,0,1,1);
        ovf_seq[5] = mk(0,0,0,    0,0,0,    4,5, 0,0,0,    0,0,0,1);

        do_reset();
        for (int i = 0; i < 8; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

        do_reset();
        for (int i = 0; i < 6; i++) run_vec($sformatf("ovf%0d", i), ovf_seq[i]);

        // Queued r6 overtaken by a younger writeback of r6.
        do_reset();
        run_vec("waw0", mk(1,2,'h2, 1,6,'h66, 6,0, 1,2,'h2, 0,1,0,0));
        run_vec("waw1", mk(1,6,'h1, 0,0,0,    6,0, 1,6,'h1, 0,1,0,0));
        run_vec("waw2", mk(0,0,0,   0,0,0,    6,0, 0,0,0,   0,0,0,0));
        run_vec("waw3", mk(0,0,0,   0,0,0,    6,0, 0,0,0,   0,0,0,0));

        // Reset landing in the middle of a drain, with a coincident result pulse.
        do_reset();
        run_vec("rst0", mk(1,1,'h1, 1,8,'h88, 8,9, 1,1,'h1, 0,1,0,0));
        run_vec("rst1", mk(1,2,'h2, 1,9,'h99, 8,9, 1,2,'h2, 0,1,1,0));
        apply(mk(0,0,0, 1,10,'hAA, 8,9, 0,0,0, 0,0,0,0));
        #1;
        check_outs("rst2.pre", 1'b1, 5'd8, 32'h88, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check_outs("rst2.async", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check_outs("rst2.hold", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        mdReady = 1'b0;
        reset   = 1'b0;
        for (int i = 0; i < 3; i++)
            run_vec($sformatf("rst_after%0d", i), mk(0,0,0, 0,0,0, 8,9, 0,0,0, 0,0,0,0));

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n > 0 && n % 150 == 0) do_reset();
            wbValid = 1'($urandom_range(0, 1));
            wbReg   = 5'($urandom_range(0, 5));
            wbData  = $urandom;
            mdReady = (mq.size() == QD) ? 1'($urandom_range(0, 9) == 0)
                                        : 1'($urandom_range(0, 4) < 2);
            mdReg   = 5'($urandom_range(0, 5));
            mdData  = $urandom;
            readA   = 5'($urandom_range(0, 5));
            readB   = 5'($urandom_range(0, 5));
            @(negedge clock);
            model_cycle(e_we, e_wd, e_wdata, e_busy, e_pa, e_pb, e_ovf);
            check_outs($sformatf("rnd%0d", n), e_we, e_wd, e_wdata, e_busy, e_pa, e_pb, e_ovf);
            @(posedge clock);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
